// File: rtl/blink_timer_datapath.sv
// Blinking-light timing datapath: prescaled saturating phase counter, limit comparator,
// and an optional completed-phase counter enabled by BLINK_DP_PERIOD_CNT_EN.
module blink_timer_datapath #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1,
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [WIDTH-1:0]    cmp_a,
    input  logic [WIDTH-1:0]    cmp_b,
    output logic [WIDTH-1:0]    count,
    output logic                match,
    output logic                tick,
    output logic                sat,
    output logic [PERIOD_W-1:0] periods
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             sat_q, sat_d;
    logic             inc;
    logic             at_max;

    // clear wins over a coinciding increment, so that edge leaves tick low
    always_comb begin
        inc     = (pre_q == PRE_LAST) && !clear;
        at_max  = (count_q == CNT_MAX);
        pre_d   = (clear || inc) ? '0 : pre_q + 1'b1;
        count_d = count_q;
        sat_d   = sat_q;
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc) begin
            if (at_max) sat_d   = 1'b1;
            else        count_d = count_q + 1'b1;
        end
        tick_d  = inc && !at_max;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            sat_q   <= sat_d;
        end
    end

    // A zero limit never matches, so the STOP phase never reports done
    assign match = (cmp_a == cmp_b) && (cmp_b != '0);
    assign count = count_q;
    assign tick  = tick_q;
    assign sat   = sat_q;

`ifdef BLINK_DP_PERIOD_CNT_EN
    logic [PERIOD_W-1:0] periods_q, periods_d;

    // The controller clears on the phase-end transition, so clear && match marks a finished phase
    always_comb begin
        periods_d = periods_q;
        if (clear && match && (periods_q != '1)) periods_d = periods_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) periods_q <= '0;
        else       periods_q <= periods_d;
    end

    assign periods = periods_q;
`else
    assign periods = '0;
`endif

endmodule

// File: tb/tb_blink_timer_datapath.sv
// Self-checking bench for blink_timer_datapath: PRESCALE=1 and PRESCALE=4 instances against
// an elapsed-time reference model; honours BLINK_DP_PERIOD_CNT_EN for the periods counter.
module tb_blink_timer_datapath;

    logic       clk;
    logic       reset;
    logic       clr   [2];
    logic [3:0] adrv  [2];
    logic [3:0] cmpa  [2];
    logic [3:0] cmpb  [2];
    logic       loopb [2];
    logic [3:0] cnt   [2];
    logic       mat   [2];
    logic       tck   [2];
    logic       sat   [2];
    logic [7:0] per   [2];

    int checks = 0;
    int errors = 0;

    // Model: edges with clear low since the last clear/reset, plus periods and last-edge tick
    int el   [2];
    int mper [2];
    bit mt   [2];
    int pp   [2] = '{1, 4};

    assign cmpa[0] = loopb[0] ? cnt[0] : adrv[0];
    assign cmpa[1] = loopb[1] ? cnt[1] : adrv[1];

    blink_timer_datapath #(.WIDTH(4), .PRESCALE(1), .PERIOD_W(8)) dut_p1 (
        .clk(clk), .reset(reset), .clear(clr[0]), .cmp_a(cmpa[0]), .cmp_b(cmpb[0]),
        .count(cnt[0]), .match(mat[0]), .tick(tck[0]), .sat(sat[0]), .periods(per[0])
    );

    blink_timer_datapath #(.WIDTH(4), .PRESCALE(4), .PERIOD_W(8)) dut_p4 (
        .clk(clk), .reset(reset), .clear(clr[1]), .cmp_a(cmpa[1]), .cmp_b(cmpb[1]),
        .count(cnt[1]), .match(mat[1]), .tick(tck[1]), .sat(sat[1]), .periods(per[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int mcount(int i);
        int c;
        c = el[i] / pp[i];
        return (c > 15) ? 15 : c;
    endfunction

    function automatic int mmatch(int i);
        int a;
        a = loopb[i] ? mcount(i) : int'(adrv[i]);
        return ((a == int'(cmpb[i])) && (cmpb[i] != 0)) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            el[i]   = 0;
            mper[i] = 0;
            mt[i]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        int m;
        if (reset) return;
        for (int i = 0; i < 2; i++) begin
            m     = mmatch(i);
            mt[i] = 1'b0;
            if (clr[i]) begin
`ifdef BLINK_DP_PERIOD_CNT_EN
                if (m == 1 && mper[i] < 255) mper[i]++;
`endif
                el[i] = 0;
            end else begin
                el[i]++;
                if ((el[i] % pp[i] == 0) && (el[i] / pp[i] <= 15)) mt[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("count[P%0d]", pp[i]),   cnt[i], mcount(i));
            check($sformatf("match[P%0d]", pp[i]),   mat[i], mmatch(i));
            check($sformatf("tick[P%0d]", pp[i]),    tck[i], mt[i]);
            check($sformatf("sat[P%0d]", pp[i]),     sat[i], (el[i] / pp[i] >= 16) ? 1 : 0);
            check($sformatf("periods[P%0d]", pp[i]), per[i], mper[i]);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b0; adrv[i] = 4'd0; cmpb[i] = 4'd5; loopb[i] = 1'b1;
        end
        model_reset();
        #1;
        check_all();
        step();
        step();

        // Release: P=1 counts every edge, P=4 reaches limit 5 after 20 edges
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("p1_ramp_count", cnt[0], k);
            check("p1_ramp_tick", tck[0], 1);
        end
        check("p1_match_at5", mat[0], 1);
        repeat (14) step();
        check("p4_match_before", mat[1], 0);
        step();
        check("p4_match_at20", mat[1], 1);
        check("p4_count_at20", cnt[1], 5);

        // Zero limit held in clear never matches
        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b1; cmpb[i] = 4'd0;
        end
        repeat (5) step();
        check("zero_limit_match", mat[0], 0);

        // Saturation at P=1
        clr[0] = 1'b0; clr[1] = 1'b0;
        repeat (15) step();
        check("sat_count15", cnt[0], 15);
        check("sat_not_yet", sat[0], 0);
        step();
        check("sat_set", sat[0], 1);
        check("sat_no_wrap", cnt[0], 15);
        repeat (4) step();
        clr[0] = 1'b1;
        step();
        check("sat_clear_count", cnt[0], 0);
        check("sat_clear_flag", sat[0], 0);

        // Closed loop: controller clears on match and alternates ON=5 / OFF=7
        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b1; cmpb[i] = 4'd5; loopb[i] = 1'b1;
        end
        step();
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 2; i++) clr[i] = (mmatch(i) == 1);
            step();
            for (int i = 0; i < 2; i++)
                if (clr[i]) cmpb[i] = (cmpb[i] == 4'd5) ? 4'd7 : 4'd5;
        end

        // Async reset at count=3, pre=2 on the P=4 instance
        clr[1] = 1'b1; cmpb[1] = 4'd5; clr[0] = 1'b0;
        step();
        clr[1] = 1'b0;
        repeat (14) step();
        check("p4_count3", cnt[1], 3);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        check("async_count", cnt[1], 0);
        check("async_periods", per[1], 0);
        #1;
        reset = 1'b0;
        repeat (3) step();
        check("post_reset_hold", cnt[1], 0);
        step();
        check("post_reset_first", cnt[1], 1);
        check("post_reset_tick", tck[1], 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                clr[i]  = ($urandom_range(7) == 0);
                adrv[i] = 4'($urandom_range(15));
                if ($urandom_range(9) == 0) cmpb[i]  = 4'($urandom_range(15));
                if ($urandom_range(15) == 0) loopb[i] = 1'($urandom_range(1));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
